// File: rtl/multi_digit_bcd_to_binary.sv
// Sequential packed-BCD to unsigned binary converter.
// Reverse double-dabble: one result bit per clock.
//
// Ports:
//   clk, reset   rising-edge clock, sync active-high reset
//   start        request; taken only when idle
//   bcd_in       DIGITS packed BCD digits, units in [3:0]
//   bin_out      result, held until next done
//   busy         high while shifting
//   done         one-cycle completion pulse
//   err          invalid digit or overflow, held with bin_out
module multi_digit_bcd_to_binary #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FIN
  } state_t;

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               inv_q, inv_d;
  logic [BIN_W-1:0]   bin_out_q, bin_out_d;
  logic               err_q, err_d;
  logic               done_q, done_d;

  logic               bad_digit;
  logic [BCD_W-1:0]   sh_bcd;
  logic [BIN_W-1:0]   sh_bin;
  logic [BCD_W-1:0]   fix_bcd;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) begin
        bad_digit = 1'b1;
      end
    end
  end

  // Shift the pair right, then pull every digit that
  // received a carry-in (>=8) back into BCD range.
  always_comb begin
    {sh_bcd, sh_bin} = {bcd_q, bin_q} >> 1;
    fix_bcd = sh_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (sh_bcd[4*i +: 4] >= 4'd8) begin
        fix_bcd[4*i +: 4] = sh_bcd[4*i +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    inv_d     = inv_q;
    bin_out_d = bin_out_q;
    err_d     = err_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d   = bcd_in;
          bin_d   = '0;
          cnt_d   = '0;
          inv_d   = bad_digit;
          state_d = bad_digit ? FIN : CONV;
        end
      end
      CONV: begin
        bcd_d = fix_bcd;
        bin_d = sh_bin;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        done_d    = 1'b1;
        // A nonzero BCD remainder means BIN_W is too narrow.
        err_d     = inv_q | (|bcd_q);
        bin_out_d = err_d ? '0 : bin_q;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      inv_q     <= 1'b0;
      bin_out_q <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      inv_q     <= inv_d;
      bin_out_q <= bin_out_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  assign bin_out = bin_out_q;
  assign busy    = (state_q == CONV);
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_multi_digit_bcd_to_binary.sv
// Bench for multi_digit_bcd_to_binary.
// Default 4-digit instance plus a 2-digit instance.
module tb_multi_digit_bcd_to_binary;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [13:0] bin_out;
  logic        busy, done, err;

  logic        start2 = 1'b0;
  logic [7:0]  bcd2 = '0;
  logic [6:0]  bin2;
  logic        busy2, done2, err2;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  typedef struct packed {
    logic [13:0] b;
    logic        e;
  } exp_t;

  exp_t exp_q[$];

  multi_digit_bcd_to_binary dut (
    .clk(clk), .reset(reset), .start(start),
    .bcd_in(bcd_in), .bin_out(bin_out),
    .busy(busy), .done(done), .err(err)
  );

  multi_digit_bcd_to_binary #(
    .DIGITS(2), .BIN_W(7)
  ) dut2 (
    .clk(clk), .reset(reset), .start(start2),
    .bcd_in(bcd2), .bin_out(bin2),
    .busy(busy2), .done(done2), .err(err2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  function automatic exp_t model(input logic [15:0] v);
    exp_t r;
    int   acc;
    int   w;
    logic [3:0] d;
    acc = 0;
    w = 1;
    r.e = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = v[4*i +: 4];
      if (d > 4'd9) r.e = 1'b1;
      acc += int'(d) * w;
      w *= 10;
    end
    r.b = r.e ? 14'd0 : 14'(acc);
    return r;
  endfunction

  // Caller is between a negedge and the next posedge.
  task automatic launch(input logic [15:0] v);
    start = 1'b1;
    bcd_in = v;
    exp_q.push_back(model(v));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // idx 0 is the negedge right after the accepting edge.
  task automatic wait_done(output int idx, output bit ok,
                           output int busy_n);
    idx = -1;
    ok = 1'b0;
    busy_n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        idx = k;
        ok = 1'b1;
        break;
      end
      if (busy) busy_n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bin_out, busy, done, err} !== 17'd0) begin
      failures++;
      $display("FAIL reset_state got=%h want=0",
               {bin_out, busy, done, err});
    end
    checks++;
    if ({bin2, busy2, done2, err2} !== 10'd0) begin
      failures++;
      $display("FAIL reset_state2 got=%h want=0",
               {bin2, busy2, done2, err2});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single(input logic [15:0] v, input string nm);
    int idx, bn;
    bit ok;
    exp_t e;
    @(negedge clk);
    launch(v);
    wait_done(idx, ok, bn);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_timeout got=no_done want=done", nm);
      exp_q.delete();
      return;
    end
    checks++;
    if (idx !== 15 || bn !== 14) begin
      failures++;
      $display("FAIL %s_latency got=%0d/%0d want=15/14",
               nm, idx, bn);
    end
    e = exp_q.pop_front();
    checks++;
    if (bin_out !== e.b || err !== e.e) begin
      failures++;
      $display("FAIL %s_value got=%0d/%b want=%0d/%b",
               nm, bin_out, err, e.b, e.e);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || bin_out !== e.b) begin
      failures++;
      $display("FAIL %s_hold got=%b/%0d want=0/%0d",
               nm, done, bin_out, e.b);
    end
  endtask

  task automatic test_invalid();
    int idx, bn;
    bit ok;
    exp_t e;
    @(negedge clk);
    launch(16'h12A4);
    wait_done(idx, ok, bn);
    checks++;
    if (!ok || idx !== 1 || bn !== 0) begin
      failures++;
      $display("FAIL invalid_timing got=%0d/%0d/%0d want=1/1/0",
               ok, idx, bn);
    end
    e = exp_q.pop_front();
    checks++;
    if (bin_out !== 14'd0 || err !== 1'b1 || e.e !== 1'b1) begin
      failures++;
      $display("FAIL invalid_value got=%0d/%b want=0/1",
               bin_out, err);
    end
  endtask

  task automatic test_back_to_back();
    int idx, bn;
    bit ok;
    exp_t e;
    @(negedge clk);
    launch(16'h9999);
    wait_done(idx, ok, bn);
    e = exp_q.pop_front();
    checks++;
    if (!ok || bin_out !== 14'd9999 || err !== e.e) begin
      failures++;
      $display("FAIL b2b_first got=%0d/%b want=9999/0",
               bin_out, err);
    end
    launch(16'h0000);
    wait_done(idx, ok, bn);
    e = exp_q.pop_front();
    checks++;
    if (!ok || idx !== 15 || bin_out !== e.b || err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second got=%0d/%0d/%b want=15/%0d/0",
               idx, bin_out, err, e.b);
    end
  endtask

  task automatic test_ignore_start();
    int idx, bn, c0;
    bit ok;
    exp_t e;
    @(negedge clk);
    c0 = done_cnt;
    launch(16'h0100);
    repeat (4) @(negedge clk);
    start = 1'b1;
    bcd_in = 16'h0055;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(idx, ok, bn);
    e = exp_q.pop_front();
    checks++;
    if (!ok || bin_out !== 14'd100 || bin_out !== e.b) begin
      failures++;
      $display("FAIL ignore_value got=%0d want=100", bin_out);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt !== c0 + 1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL ignore_pulses got=%0d want=1",
               done_cnt - c0);
    end
  endtask

  task automatic test_reset_abort();
    int c0;
    @(negedge clk);
    launch(16'h0777);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    c0 = done_cnt;
    @(negedge clk);
    checks++;
    if ({bin_out, busy, done, err} !== 17'd0) begin
      failures++;
      $display("FAIL abort_state got=%h want=0",
               {bin_out, busy, done, err});
    end
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt !== c0 || bin_out !== 14'd0) begin
      failures++;
      $display("FAIL abort_quiet got=%0d/%0d want=0/0",
               done_cnt - c0, bin_out);
    end
    test_single(16'h0777, "after_abort");
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 4; i++) begin
        v[4*i +: 4] = 4'($urandom_range(9));
      end
      test_single(v, "random");
    end
  endtask

  task automatic test_small();
    int idx;
    logic [7:0] vals [2];
    logic [6:0] want [2];
    vals[0] = 8'h99;
    vals[1] = 8'h07;
    want[0] = 7'd99;
    want[1] = 7'd7;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      start2 = 1'b1;
      bcd2 = vals[n];
      @(posedge clk);
      #1 start2 = 1'b0;
      idx = -1;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (done2) begin
          idx = k;
          break;
        end
      end
      checks++;
      if (idx !== 8 || bin2 !== want[n] || err2 !== 1'b0) begin
        failures++;
        $display("FAIL small_%0d got=%0d/%0d/%b want=8/%0d/0",
                 n, idx, bin2, err2, want[n]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single(16'h1234, "basic");
    test_single(16'h0001, "one");
    test_invalid();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    test_random();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
